// File: rtl/inv_image_pkg.sv
// ============================================================================
//  Module      : inv_image_pkg
//  Description : Shared defaults and skid-buffer state encoding for the
//                image inverter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inv_image_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_PIXEL_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage : inv_image_pkg

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
// ============================================================================
//  Module      : axis_skid_buffer
//  Description : Generic 2-entry registered AXI4-Stream slice (output + skid).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_skid_buffer
    import inv_image_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    skid_state_e           state;
    skid_state_e           next_state;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  ready_reg;
    logic                  accept;
    logic                  consume;
    logic                  load_out;
    logic                  load_skid;
    logic                  out_from_skid;

    assign accept  = s_valid && ready_reg;
    assign consume = (state != EMPTY) && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = BUSY;
                    load_out   = 1'b1;
                end
            end
            BUSY: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (consume) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                // Ready is already low here, so only the drain path exists.
                if (consume) begin
                    next_state    = BUSY;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    // Ready is registered from the next state so it never combinationally tracks m_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            ready_reg <= (next_state != FULL);
            if (load_out) begin
                out_data <= out_from_skid ? skid_data : s_data;
            end
            if (load_skid) begin
                skid_data <= s_data;
            end
        end
    end

    assign s_ready = ready_reg;
    assign m_valid = (state != EMPTY);
    assign m_data  = out_data;

endmodule : axis_skid_buffer

`default_nettype wire

// File: rtl/custom_ip_inv_image.sv
// ============================================================================
//  Module      : custom_ip_inv_image
//  Description : AXI4-Stream pixel inverter (per-lane bitwise NOT) with a
//                registered 2-entry skid buffer on the output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module custom_ip_inv_image
    import inv_image_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    input  logic                  m_axis_ready
);

    localparam int NUM_LANES = DATA_WIDTH / PIXEL_WIDTH;

    generate
        if ((DATA_WIDTH == 0) || (PIXEL_WIDTH == 0) || ((DATA_WIDTH % PIXEL_WIDTH) != 0)) begin : g_bad_width
            $fatal(1, "DATA_WIDTH must be a non-zero multiple of PIXEL_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] inverted;

    generate
        for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
            assign inverted[lane*PIXEL_WIDTH +: PIXEL_WIDTH] = ~s_axis_data[lane*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    endgenerate

    axis_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (axi_clk),
        .rst     (axi_reset),
        .s_valid (s_axis_valid),
        .s_data  (inverted),
        .s_ready (s_axis_ready),
        .m_valid (m_axis_valid),
        .m_data  (m_axis_data),
        .m_ready (m_axis_ready)
    );

endmodule : custom_ip_inv_image

`default_nettype wire

// File: tb/tb_custom_ip_inv_image.sv
// ============================================================================
//  Module      : tb_custom_ip_inv_image
//  Description : Self-checking bench for custom_ip_inv_image against a
//                queue-based stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_custom_ip_inv_image;

    localparam int DW = 32;
    localparam int PW = 8;

    logic          clk;
    logic          axi_reset;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out;
    bit            ready_ok;
    int            emitted;

    custom_ip_inv_image #(
        .DATA_WIDTH  (DW),
        .PIXEL_WIDTH (PW)
    ) dut (
        .axi_clk      (clk),
        .axi_reset    (axi_reset),
        .s_axis_valid (s_valid),
        .s_axis_data  (s_data),
        .s_axis_ready (s_ready),
        .m_axis_valid (m_valid),
        .m_axis_data  (m_data),
        .m_axis_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Photographic negative per pixel: 255 - p.
    function automatic logic [DW-1:0] negative(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        int unsigned   p;
        r = '0;
        for (int i = 0; i < DW/PW; i++) begin
            p = 255 - int'(d[i*PW +: PW]);
            r[i*PW +: PW] = p[PW-1:0];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic [DW-1:0] front;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #3;
        check("m_valid", {31'd0, m_valid}, {31'd0, exp_q.size() != 0});
        check("s_ready", {31'd0, s_ready}, {31'd0, ready_ok && (exp_q.size() < 2)});
        if (!m_valid) check("m_data_hold", m_data, last_out);
        if (!axi_reset) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 32'd1, 32'd0);
                end else begin
                    front = exp_q.pop_front();
                    check("m_data", m_data, front);
                    last_out = front;
                    emitted++;
                end
            end
            if (s_valid && s_ready) exp_q.push_back(negative(s_data));
        end
        @(posedge clk);
        #1;
        if (axi_reset) begin
            exp_q.delete();
            last_out = '0;
            ready_ok = 1'b0;
        end else begin
            ready_ok = 1'b1;
        end
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step(1'b0, DW'($urandom), 1'b1);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int            start;
        logic [DW-1:0] vec;
        logic [DW-1:0] pats [6];

        pats[0] = 32'h12345678; pats[1] = 32'h87654321; pats[2] = 32'hAABBCCDD;
        pats[3] = 32'h00000000; pats[4] = 32'hFFFFFFFF; pats[5] = 32'h00FF807F;

        axi_reset = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        last_out  = '0;
        ready_ok  = 1'b0;
        emitted   = 0;

        // Reset held two cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data",  m_data, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        axi_reset = 1'b0;
        step(1'b0, '0, 1'b0);
        check("ready_after_release", {31'd0, s_ready}, 32'd1);

        // Directed single beats, including boundary pixels.
        check("vec_12345678", negative(32'h12345678), 32'hEDCBA987);
        check("vec_00FF807F", negative(32'h00FF807F), 32'hFF007F80);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, pats[i], 1'b1);
            vec = negative(pats[i]);
            check("single_latency_data", m_valid ? m_data : 32'hDEADBEEF, vec);
            step(1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b1);
        end

        // Back-pressure fills both entries.
        step(1'b1, 32'h11111111, 1'b0);
        step(1'b1, 32'h22222222, 1'b0);
        check("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
        check("bp_hold_data", m_data, 32'hEEEEEEEE);
        step(1'b1, 32'h33333333, 1'b0);
        check("bp_still_held", m_data, 32'hEEEEEEEE);
        step(1'b0, '0, 1'b1);
        check("bp_second_out", m_data, 32'hDDDDDDDD);
        drain(8);

        // Sustained streaming: 16 beats, 16 consecutive outputs.
        start = emitted;
        for (int i = 0; i < 16; i++) step(1'b1, DW'($urandom), 1'b1);
        step(1'b0, '0, 1'b1);
        check("stream_count", 32'(emitted - start), 32'd16);

        // Reset with a full buffer discards everything.
        step(1'b1, 32'hCAFEF00D, 1'b0);
        step(1'b1, 32'h0BADBEEF, 1'b0);
        check("pre_rst_full", {31'd0, s_ready}, 32'd0);
        axi_reset = 1'b1;
        step(1'b0, '0, 1'b0);
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_m_data",  m_data, 32'd0);
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        axi_reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_custom_ip_inv_image

`default_nettype wire
